// File: rtl/vr_pkt_gen.sv
// ---------------------------------------------------------------------------
// vr_pkt_gen
// Burst packet generator on a valid/ready stream. A start request latches a
// packet length, a packet count, an inter-packet gap and a seed. The block
// then emits pkt_num packets of pkt_len beats each. Beat data is an
// incrementing counter that starts at the seed and keeps counting across
// packet boundaries.
//
// Parameters
//   DATA_W      tx data width
//   LEN_W       width of packet length, packet count and counter fields
//   TP          register update delay for simulation (zero-delay here)
//
// Ports
//   clk_i       clock, all logic on the rising edge
//   rsn_i       synchronous reset, active-low
//   clr_i       synchronous clear, active-high (same effect as reset)
//   start_i     single-cycle burst request, honoured only in IDLE
//   pkt_len_i   beats per packet (0 -> request ignored)
//   pkt_num_i   packets per burst (0 -> request ignored)
//   gap_i       idle cycles between packets
//   seed_i      data value of the first beat
//   tx_data_o   stream data
//   tx_vld_o    stream valid
//   tx_last_o   final beat of each packet
//   tx_rdy_i    consumer ready
//   busy_o      high whenever the FSM is not IDLE
//   done_o      one-cycle pulse after the final beat of a burst
//   pkt_cnt_o   packets fully accepted in the current/most recent burst
//   stall_cnt_o (VR_PKT_GEN_PERF_EN only) saturating count of cycles with
//               tx_vld_o=1 and tx_rdy_i=0
//
// Build option
//   VR_PKT_GEN_PERF_EN  adds the stall_cnt_o performance counter
// ---------------------------------------------------------------------------
module vr_pkt_gen #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int TP     = 1
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  pkt_len_i,
  input  logic [LEN_W-1:0]  pkt_num_i,
  input  logic [7:0]        gap_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_vld_o,
  output logic              tx_last_o,
  input  logic              tx_rdy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  pkt_cnt_o
`ifdef VR_PKT_GEN_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  num_q;
  logic [7:0]        gap_q;
  logic [7:0]        gap_cnt_q;
  logic [LEN_W-1:0]  beat_q;

  logic              start_ok;
  logic              beat;
  logic [LEN_W-1:0]  beat_nxt;
  logic [LEN_W-1:0]  pkt_cnt_nxt;
  logic              tp_unused;

  // TP is accepted for compatibility with delayed-update simulation models;
  // this implementation updates registers with zero delay.
  assign tp_unused = (TP != 0);

  // A request is honoured only in IDLE and only when it describes a
  // non-empty burst; anything else leaves the FSM untouched.
  assign start_ok = (state_q == IDLE) && start_i &&
                    (pkt_len_i != '0) && (pkt_num_i != '0);

  assign beat        = tx_vld_o && tx_rdy_i;
  assign beat_nxt    = beat_q + LEN_ONE;
  assign pkt_cnt_nxt = pkt_cnt_o + LEN_ONE;

  // Main FSM. beat_q holds the 1-based index of the beat currently
  // presented, so tx_last_o can be registered one beat ahead. All stream
  // outputs only change on a handshake, which keeps them stable under stall.
  always_ff @(posedge clk_i) begin
    if (!rsn_i || clr_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      beat_q    <= '0;
      tx_data_o <= '0;
      tx_vld_o  <= 1'b0;
      tx_last_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pkt_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q   <= SEND;
            len_q     <= pkt_len_i;
            num_q     <= pkt_num_i;
            gap_q     <= gap_i;
            beat_q    <= LEN_ONE;
            tx_data_o <= seed_i;
            tx_vld_o  <= 1'b1;
            tx_last_o <= (pkt_len_i == LEN_ONE);
            busy_o    <= 1'b1;
            pkt_cnt_o <= '0;
          end
        end

        SEND: begin
          if (beat) begin
            tx_data_o <= tx_data_o + DATA_ONE;
            if (tx_last_o) begin
              pkt_cnt_o <= pkt_cnt_nxt;
              beat_q    <= LEN_ONE;
              if (pkt_cnt_nxt == num_q) begin
                state_q   <= IDLE;
                tx_vld_o  <= 1'b0;
                tx_last_o <= 1'b0;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
              end else if (gap_q == 8'd0) begin
                tx_last_o <= (len_q == LEN_ONE);
              end else begin
                state_q   <= GAP;
                tx_vld_o  <= 1'b0;
                tx_last_o <= 1'b0;
                gap_cnt_q <= gap_q;
              end
            end else begin
              beat_q    <= beat_nxt;
              tx_last_o <= (beat_nxt == len_q);
            end
          end
        end

        GAP: begin
          // Leaving on a count of 1 gives exactly gap_q cycles with
          // tx_vld_o low.
          if (gap_cnt_q == 8'd1) begin
            state_q   <= SEND;
            tx_vld_o  <= 1'b1;
            tx_last_o <= (len_q == LEN_ONE);
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end

        default: begin
          state_q  <= IDLE;
          tx_vld_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

`ifdef VR_PKT_GEN_PERF_EN
  // Saturating stall counter. It restarts on every accepted burst so that
  // it always describes the current or most recent burst.
  always_ff @(posedge clk_i) begin
    if (!rsn_i || clr_i || start_ok) begin
      stall_cnt_o <= '0;
    end else if (tx_vld_o && !tx_rdy_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vr_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_vr_pkt_gen
// Self-checking bench for vr_pkt_gen. Inputs are driven and outputs are
// sampled on the falling clock edge. Each burst is tracked by a reference
// model that lists the expected beat sequence (seed+k, last on every
// pkt_len-th beat), the expected idle run between packets and the done and
// packet-count behaviour. A table of directed bursts is followed by
// randomized bursts and by hand-written abort and stall sequences.
// Define VR_PKT_GEN_PERF_EN to also exercise stall_cnt_o.
// ---------------------------------------------------------------------------
module tb_vr_pkt_gen;

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rsn_i;
  logic        clr_i;
  logic        start_i;
  logic [15:0] pkt_len_i;
  logic [15:0] pkt_num_i;
  logic [7:0]  gap_i;
  logic [31:0] seed_i;
  logic [31:0] tx_data_o;
  logic        tx_vld_o;
  logic        tx_last_o;
  logic        tx_rdy_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pkt_cnt_o;
`ifdef VR_PKT_GEN_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] seed;
    logic [15:0] len;
    logic [15:0] num;
    logic [7:0]  gap;
    int          rdy_pct;
    int          exp_beats;
    logic [31:0] exp_last;
    int          exp_low;
  } vec_t;

  vec_t vecs[4];

  vr_pkt_gen #(.DATA_W(32), .LEN_W(16), .TP(1)) dut (
    .clk_i      (clk),
    .rsn_i      (rsn_i),
    .clr_i      (clr_i),
    .start_i    (start_i),
    .pkt_len_i  (pkt_len_i),
    .pkt_num_i  (pkt_num_i),
    .gap_i      (gap_i),
    .seed_i     (seed_i),
    .tx_data_o  (tx_data_o),
    .tx_vld_o   (tx_vld_o),
    .tx_last_o  (tx_last_o),
    .tx_rdy_i   (tx_rdy_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pkt_cnt_o  (pkt_cnt_o)
`ifdef VR_PKT_GEN_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // One comparison: bumps the totals and reports any difference.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic start, input logic [15:0] len, input logic [15:0] num,
                               input logic [7:0] gap, input logic [31:0] seed);
    start_i   = start;
    pkt_len_i = len;
    pkt_num_i = num;
    gap_i     = gap;
    seed_i    = seed;
  endtask

  function automatic logic pickReady(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  // Idle cycles: nothing may be sent and the last packet count must hold.
  task automatic idleCycles(input string tag, input int n, input logic [15:0] exp_cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      checkOutput({tag, " idle vld"},  tx_vld_o, 0);
      checkOutput({tag, " idle busy"}, busy_o, 0);
      checkOutput({tag, " idle done"}, done_o, 0);
      checkOutput({tag, " idle cnt"},  pkt_cnt_o, exp_cnt);
    end
  endtask

  // Starts a burst at the current falling edge and follows it to done_o.
  // Returns at the falling edge where done_o is seen, so a following call
  // issues its start in the same cycle as done_o. restart_at>0 pulses a
  // second start (with different parameters) that must be ignored.
  task automatic runBurst(input string tag, input logic [31:0] seed, input logic [15:0] len,
                          input logic [15:0] num, input logic [7:0] gap, input int rdy_pct,
                          input int restart_at, output int n_beats, output logic [31:0] last_data,
                          output int low_total);
    logic [31:0] exp_data;
    int          beat_no, pkt_done, low_run, cyc;
    bit          await_next, fin;
    applyStimulus(1'b1, len, num, gap, seed);
    tx_rdy_i   = pickReady(rdy_pct);
    exp_data   = seed;
    beat_no    = 1;
    pkt_done   = 0;
    low_run    = 0;
    low_total  = 0;
    n_beats    = 0;
    last_data  = '0;
    await_next = 1'b0;
    fin        = 1'b0;
    cyc        = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == restart_at);
      if (cyc == restart_at) begin
        pkt_len_i = 16'd1;
        seed_i    = 32'hDEAD_0000;
      end
      tx_rdy_i = pickReady(rdy_pct);
      if (pkt_done == int'(num)) begin
        checkOutput({tag, " done"},      done_o, 1);
        checkOutput({tag, " end vld"},   tx_vld_o, 0);
        checkOutput({tag, " end busy"},  busy_o, 0);
        checkOutput({tag, " end cnt"},   pkt_cnt_o, num);
        start_i = 1'b0;
        fin     = 1'b1;
      end else if (cyc > BUDGET) begin
        checkOutput({tag, " timeout"}, 0, 1);
        start_i = 1'b0;
        fin     = 1'b1;
      end else begin
        checkOutput({tag, " done low"}, done_o, 0);
        checkOutput({tag, " busy"},     busy_o, 1);
        checkOutput({tag, " pkt cnt"},  pkt_cnt_o, 64'(pkt_done));
        if (tx_vld_o) begin
          if (await_next) begin
            checkOutput({tag, " gap len"}, 64'(low_run), 64'(gap));
            await_next = 1'b0;
          end
          checkOutput({tag, " data"}, tx_data_o, exp_data);
          checkOutput({tag, " last"}, tx_last_o, (beat_no == int'(len)));
          if (tx_rdy_i) begin
            n_beats++;
            last_data = exp_data;
            exp_data  = exp_data + 32'd1;
            if (beat_no == int'(len)) begin
              pkt_done++;
              beat_no = 1;
              if (pkt_done != int'(num)) begin
                await_next = 1'b1;
                low_run    = 0;
              end
            end else begin
              beat_no++;
            end
          end
        end else if (await_next) begin
          low_run++;
          low_total++;
        end else begin
          checkOutput({tag, " unexpected idle"}, tx_vld_o, 1);
        end
      end
    end
  endtask

  initial begin
    int          nb, lowt, rlen, rnum, rgap, rpct, rre;
    logic [31:0] ld, rseed;

    vecs[0] = '{32'h0000_0010, 16'd4, 16'd2, 8'd0, 100, 8, 32'h0000_0017, 0};
    vecs[1] = '{32'h0000_0040, 16'd2, 16'd3, 8'd3, 100, 6, 32'h0000_0045, 6};
    vecs[2] = '{32'hFFFF_FFFE, 16'd5, 16'd1, 8'd0, 50,  5, 32'h0000_0002, 0};
    vecs[3] = '{32'h0000_0007, 16'd1, 16'd4, 8'd1, 70,  4, 32'h0000_000A, 3};

    // Reset held with a valid start pending: reset must win.
    rsn_i    = 1'b0;
    clr_i    = 1'b0;
    tx_rdy_i = 1'b1;
    applyStimulus(1'b1, 16'd4, 16'd2, 8'd0, 32'h1234);
    repeat (3) @(negedge clk);
    checkOutput("reset vld",  tx_vld_o, 0);
    checkOutput("reset last", tx_last_o, 0);
    checkOutput("reset data", tx_data_o, 0);
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset done", done_o, 0);
    checkOutput("reset cnt",  pkt_cnt_o, 0);
    rsn_i   = 1'b1;
    start_i = 1'b0;

    // Requests describing an empty burst are ignored.
    applyStimulus(1'b1, 16'd0, 16'd3, 8'd0, 32'h55);
    idleCycles("len0", 3, 16'd0);
    applyStimulus(1'b1, 16'd4, 16'd0, 8'd0, 32'h55);
    idleCycles("num0", 3, 16'd0);

    // Directed table; even entries chain straight into the next start.
    for (int i = 0; i < 4; i++) begin
      runBurst($sformatf("vec%0d", i), vecs[i].seed, vecs[i].len, vecs[i].num, vecs[i].gap,
               vecs[i].rdy_pct, 0, nb, ld, lowt);
      checkOutput($sformatf("vec%0d beats", i), 64'(nb), 64'(vecs[i].exp_beats));
      checkOutput($sformatf("vec%0d last data", i), ld, vecs[i].exp_last);
      checkOutput($sformatf("vec%0d low cycles", i), 64'(lowt), 64'(vecs[i].exp_low));
      if (i % 2 == 1) idleCycles($sformatf("vec%0d", i), 2, vecs[i].num);
    end

    // Second start while busy must not disturb the running burst.
    runBurst("busy start", 32'h300, 16'd3, 16'd2, 8'd2, 100, 4, nb, ld, lowt);
    checkOutput("busy start beats", 64'(nb), 6);
    checkOutput("busy start last",  ld, 32'h305);
    idleCycles("busy start", 2, 16'd2);

    // Randomized bursts against closed-form expectations.
    for (int i = 0; i < 8; i++) begin
      rseed = $urandom;
      rlen  = int'($urandom_range(6, 1));
      rnum  = int'($urandom_range(4, 1));
      rgap  = int'($urandom_range(4, 0));
      rpct  = int'($urandom_range(100, 30));
      rre   = (i % 2 == 0) ? int'($urandom_range(rlen * rnum, 1)) : 0;
      runBurst($sformatf("rand%0d", i), rseed, 16'(rlen), 16'(rnum), 8'(rgap), rpct, rre,
               nb, ld, lowt);
      checkOutput($sformatf("rand%0d beats", i), 64'(nb), 64'(rlen * rnum));
      checkOutput($sformatf("rand%0d last data", i), ld, rseed + 32'(rlen * rnum - 1));
      checkOutput($sformatf("rand%0d low cycles", i), 64'(lowt), 64'(rgap * (rnum - 1)));
      idleCycles($sformatf("rand%0d", i), int'($urandom_range(2, 0)), 16'(rnum));
    end

    // clr_i on beat 3 of an 8-beat packet aborts without done_o.
    @(negedge clk);
    applyStimulus(1'b1, 16'd8, 16'd1, 8'd0, 32'h100);
    tx_rdy_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      start_i = 1'b0;
      checkOutput($sformatf("clr beat%0d", b + 1), tx_data_o, 32'h100 + 32'(b));
    end
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    checkOutput("clr vld",  tx_vld_o, 0);
    checkOutput("clr last", tx_last_o, 0);
    checkOutput("clr busy", busy_o, 0);
    checkOutput("clr done", done_o, 0);
    checkOutput("clr cnt",  pkt_cnt_o, 0);
    idleCycles("after clr", 2, 16'd0);
    runBurst("post clr", 32'h5A0, 16'd3, 16'd2, 8'd1, 100, 0, nb, ld, lowt);
    checkOutput("post clr beats", 64'(nb), 6);
    checkOutput("post clr last",  ld, 32'h5A5);
    idleCycles("post clr", 1, 16'd2);

    // rsn_i mid-packet behaves like clr_i.
    applyStimulus(1'b1, 16'd4, 16'd2, 8'd0, 32'h900);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("rst mid data", tx_data_o, 32'h901);
    rsn_i = 1'b0;
    @(negedge clk);
    rsn_i = 1'b1;
    checkOutput("rst mid vld",  tx_vld_o, 0);
    checkOutput("rst mid data0", tx_data_o, 0);
    checkOutput("rst mid busy", busy_o, 0);
    idleCycles("after rst", 2, 16'd0);

`ifdef VR_PKT_GEN_PERF_EN
    // Seven stalled cycles while valid, then drain the packet.
    applyStimulus(1'b1, 16'd4, 16'd1, 8'd0, 32'h0);
    tx_rdy_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (k == 1) checkOutput("stall start", stall_cnt_o, 0);
    end
    @(negedge clk);
    checkOutput("stall count", stall_cnt_o, 7);
    checkOutput("stall hold",  tx_data_o, 0);
    tx_rdy_i = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("stall done",  done_o, 1);
    checkOutput("stall final", stall_cnt_o, 7);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
